// File: rtl/tile_map_pkg.sv
// tile_map_pkg: direction/tile codes, map limits and the tile classifier shared by the mover and pixel generator
package tile_map_pkg;

    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_e;
    typedef enum logic [1:0] {TILE_PATH, TILE_BLOCK, TILE_WATER} tile_e;
    typedef enum logic [1:0] {IDLE, ARMED, EVAL, COOL} mover_state_e;

    localparam int HMAX_TILE = 9;
    localparam int VMAX_TILE = 5;

    // Every third column is water; otherwise every fourth row is a wall
    function automatic tile_e tile_class(input logic [3:0] h, input logic [3:0] v);
        return (h % 4'd3 == 4'd0) ? TILE_WATER : (v[1:0] == 2'b00) ? TILE_BLOCK : TILE_PATH;
    endfunction

endpackage

// File: rtl/tile_mover_passable.sv
// tile_passable: combinational passability of a tile; TILE_MOVER_SWIM_EN makes water passable
module tile_passable
    import tile_map_pkg::*;
(
    input  logic [3:0] h,
    input  logic [3:0] v,
    output logic       pass
);

    tile_e cls;

    assign cls = tile_class(h, v);
`ifdef TILE_MOVER_SWIM_EN
    assign pass = cls != TILE_BLOCK;
`else
    assign pass = cls == TILE_PATH;
`endif

endmodule

// File: rtl/tile_mover.sv
// tile_mover: captures key pulses, validates the move against the tile map and commits it on frame_start,
// then waits a number of frames before accepting the next key (water passable when TILE_MOVER_SWIM_EN)
module tile_mover
    import tile_map_pkg::*;
#(
    parameter int HMAX            = HMAX_TILE,
    parameter int VMAX            = VMAX_TILE,
    parameter int START_H         = 1,
    parameter int START_V         = 1,
    parameter int COOLDOWN_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    output logic [3:0] cur_ah,
    output logic [3:0] cur_av,
    output logic       moved,
    output logic       blocked
);

    mover_state_e state_q, state_d;
    dir_e         pend_q, pend_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [3:0]   ah_q, ah_d, av_q, av_d;
    logic         moved_q, moved_d, blocked_q, blocked_d;
    logic         any_key, capture, in_range, pass, ok, commit;
    dir_e         key_dir;
    logic [4:0]   th, tv;

    assign any_key = key_up | key_down | key_left | key_right;
    assign key_dir = key_up ? DIR_UP : key_down ? DIR_DOWN : key_left ? DIR_LEFT : DIR_RIGHT;
    assign capture = any_key && (state_q == IDLE || (state_q == ARMED && !frame_start));

    // A step below zero shows up as bit 4 set, so no wrap-around is possible
    assign th = {1'b0, ah_q} + (pend_q == DIR_RIGHT ? 5'd1 : pend_q == DIR_LEFT ? 5'h1f : 5'd0);
    assign tv = {1'b0, av_q} + (pend_q == DIR_DOWN ? 5'd1 : pend_q == DIR_UP ? 5'h1f : 5'd0);
    assign in_range = !th[4] && !tv[4] && th <= 5'(HMAX) && tv <= 5'(VMAX);
    assign ok = in_range && pass;
    assign commit = state_q == EVAL && ok;

    tile_passable u_pass (
        .h    (th[3:0]),
        .v    (tv[3:0]),
        .pass (pass)
    );

    // State and datapath registers; reset abandons any pending move
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pend_q    <= DIR_UP;
            cnt_q     <= '0;
            ah_q      <= 4'(START_H);
            av_q      <= 4'(START_V);
            moved_q   <= 1'b0;
            blocked_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            cnt_q     <= cnt_d;
            ah_q      <= ah_d;
            av_q      <= av_d;
            moved_q   <= moved_d;
            blocked_q <= blocked_d;
        end
    end

    // Next-state: a key arms, frame_start evaluates, cooldown drains on frame_start
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = any_key ? ARMED : IDLE;
            ARMED:   state_d = frame_start ? EVAL : ARMED;
            EVAL:    state_d = COOLDOWN_FRAMES > 0 ? COOL : IDLE;
            default: state_d = (frame_start && cnt_q == 8'd1) ? IDLE : COOL;
        endcase
    end

    // Outputs and datapath: latest key wins, position and pulses update from EVAL
    always_comb begin
        pend_d    = capture ? key_dir : pend_q;
        cnt_d     = state_q == EVAL ? 8'(COOLDOWN_FRAMES) : (state_q == COOL && frame_start) ? cnt_q - 8'd1 : cnt_q;
        ah_d      = commit ? th[3:0] : ah_q;
        av_d      = commit ? tv[3:0] : av_q;
        moved_d   = commit;
        blocked_d = state_q == EVAL && !ok;
    end

    assign cur_ah  = ah_q;
    assign cur_av  = av_q;
    assign moved   = moved_q;
    assign blocked = blocked_q;

endmodule
